// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 key-scheduling engine.
package rc4_pkg;

    typedef enum logic [3:0] {
        IDLE, INIT_WR, RD_I, CAP_I, ADD_J, RD_J, CAP_J, WR_I, WR_J, DONE
    } rc4_state_t;

    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_KEY_BYTES = 3;
    localparam int MAX_ADDR_W    = 16;
    localparam int MAX_KEY_BYTES = 32;
    localparam int MAX_KEY_BITS  = MAX_ADDR_W * MAX_KEY_BYTES;

    // Key byte 0 sits in the MSBs; caller truncates to its own byte width.
    function automatic logic [MAX_ADDR_W-1:0] key_byte_sel(
        input logic [MAX_KEY_BITS-1:0] key,
        input int                      nbytes,
        input int                      w,
        input int                      idx
    );
        return MAX_ADDR_W'(key >> ((nbytes - 1 - idx) * w));
    endfunction

endpackage

// File: rtl/rc4_ksa_engine_if.sv
// Single-port S-box RAM bus between the KSA engine and the RAM.
interface rc4_ksa_engine_if
    import rc4_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_rdata;
    logic              mem_wren;

    modport master (output mem_addr, output mem_wdata, output mem_wren, input  mem_rdata);
    modport slave  (input  mem_addr, input  mem_wdata, input  mem_wren, output mem_rdata);
endinterface

// File: rtl/rc4_key_index.sv
// Key index counter k (wraps at KEY_BYTES-1) and the key byte mux it drives.
module rc4_key_index
    import rc4_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int KEY_BYTES = DEF_KEY_BYTES
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic                        advance,
    input  logic [KEY_BYTES*ADDR_W-1:0] key,
    output logic [ADDR_W-1:0]           key_byte
);
    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    logic [KW-1:0] k;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     k <= '0;
        else if (clear)   k <= '0;
        else if (advance) k <= (k == KW'(KEY_BYTES - 1)) ? '0 : k + KW'(1);
    end

    assign key_byte = ADDR_W'(key_byte_sel(MAX_KEY_BITS'(key), KEY_BYTES, ADDR_W, int'(k)));

endmodule

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine driving an external S-box RAM with configurable read latency.
// Define RC4_INIT_EN to fill the RAM with the identity permutation before the swap loop.
module rc4_ksa_engine
    import rc4_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int KEY_BYTES    = DEF_KEY_BYTES,
    parameter int READ_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [KEY_BYTES*ADDR_W-1:0] key,
    output logic                        busy,
    output logic                        done,
    rc4_ksa_engine_if.master            mem
);
    rc4_state_t state, state_n;

    logic [ADDR_W-1:0] i, i_n, j, j_n, si, si_n, sj, sj_n;
    logic [ADDR_W-1:0] addr_q, addr_n, wdata_q, wdata_n, key_byte;
    logic [KEY_BYTES*ADDR_W-1:0] key_q, key_n;
    logic [1:0] wcnt, wcnt_n;
    logic wren_q, wren_n, busy_n, done_n, k_clr, k_adv;

    rc4_key_index #(.ADDR_W(ADDR_W), .KEY_BYTES(KEY_BYTES)) u_key_index (
        .clk(clk), .reset_n(reset_n), .clear(k_clr), .advance(k_adv),
        .key(key_q), .key_byte(key_byte)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;  i <= '0;  j <= '0;  si <= '0;  sj <= '0;
            key_q <= '0;  wcnt <= '0;  addr_q <= '0;  wdata_q <= '0;
            wren_q <= 1'b0;  busy <= 1'b0;  done <= 1'b0;
        end else begin
            state <= state_n;  i <= i_n;  j <= j_n;  si <= si_n;  sj <= sj_n;
            key_q <= key_n;  wcnt <= wcnt_n;  addr_q <= addr_n;  wdata_q <= wdata_n;
            wren_q <= wren_n;  busy <= busy_n;  done <= done_n;
        end
    end

    // Next-state logic; outputs are then derived from the next state so they come out registered.
    always_comb begin
        state_n = state;  i_n = i;  j_n = j;  si_n = si;  sj_n = sj;
        key_n = key_q;  wcnt_n = wcnt;  k_clr = 1'b0;  k_adv = 1'b0;
        addr_n = '0;  wdata_n = '0;  wren_n = 1'b0;  busy_n = 1'b1;  done_n = 1'b0;

        case (state)
            IDLE: if (start) begin
                i_n = '0;  j_n = '0;  k_clr = 1'b1;  key_n = key;  wcnt_n = '0;
`ifdef RC4_INIT_EN
                state_n = INIT_WR;
`else
                state_n = RD_I;
`endif
            end
`ifdef RC4_INIT_EN
            INIT_WR: begin
                if (i == '1) begin
                    i_n = '0;
                    state_n = RD_I;
                end else begin
                    i_n = i + ADDR_W'(1);
                end
            end
`endif
            RD_I, RD_J: begin
                if (wcnt == 2'(READ_LATENCY - 1)) begin
                    wcnt_n  = '0;
                    state_n = (state == RD_I) ? CAP_I : CAP_J;
                end else begin
                    wcnt_n = wcnt + 2'd1;
                end
            end
            CAP_I: begin si_n = mem.mem_rdata;  state_n = ADD_J; end
            ADD_J: begin j_n = j + si + key_byte;  state_n = RD_J; end
            CAP_J: begin sj_n = mem.mem_rdata;  state_n = WR_I; end
            WR_I:  state_n = WR_J;
            WR_J: begin
                k_adv = 1'b1;
                if (i == '1) begin
                    state_n = DONE;
                end else begin
                    i_n = i + ADDR_W'(1);
                    state_n = RD_I;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        case (state_n)
`ifdef RC4_INIT_EN
            INIT_WR: begin addr_n = i_n;  wdata_n = i_n;  wren_n = 1'b1; end
`endif
            RD_I:    addr_n = i_n;
            RD_J:    addr_n = j_n;
            WR_I:    begin addr_n = i_n;  wdata_n = sj_n;  wren_n = 1'b1; end
            WR_J:    begin addr_n = j_n;  wdata_n = si_n;  wren_n = 1'b1; end
            DONE:    begin busy_n = 1'b0;  done_n = 1'b1; end
            IDLE:    busy_n = 1'b0;
            default: ;
        endcase
    end

    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_wren  = wren_q;

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Self-checking bench: four engine configurations on behavioural latency RAMs vs a software KSA model.
module tb_rc4_ksa_engine;
`ifdef RC4_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    int P_W [4] = '{2, 8, 8, 8};
    int P_NB[4] = '{1, 3, 3, 16};
    int P_L [4] = '{1, 1, 2, 3};

    logic clk, reset_n;
    logic [3:0] start_v;
    logic [255:0] kv [4];
    wire  [3:0] busy_v, done_v, wren_v;
    logic [7:0] maddr [4];
    logic [7:0] wdat  [4];
    logic [7:0] ram [4][256];
    logic [7:0] rp  [4][3];
    int   wlog[$];
    logic fill_go, fill_id;
    int   fill_sel;
    int   exp_s[256];
    int   exp_wa[$];
    int   n_cmp, n_bad;

    rc4_ksa_engine_if #(.ADDR_W(2)) if0();
    rc4_ksa_engine_if #(.ADDR_W(8)) if1();
    rc4_ksa_engine_if #(.ADDR_W(8)) if2();
    rc4_ksa_engine_if #(.ADDR_W(8)) if3();

    rc4_ksa_engine #(.ADDR_W(2), .KEY_BYTES(1), .READ_LATENCY(1)) dut0 (.clk(clk), .reset_n(reset_n),
        .start(start_v[0]), .key(kv[0][1:0]), .busy(busy_v[0]), .done(done_v[0]), .mem(if0.master));
    rc4_ksa_engine #(.ADDR_W(8), .KEY_BYTES(3), .READ_LATENCY(1)) dut1 (.clk(clk), .reset_n(reset_n),
        .start(start_v[1]), .key(kv[1][23:0]), .busy(busy_v[1]), .done(done_v[1]), .mem(if1.master));
    rc4_ksa_engine #(.ADDR_W(8), .KEY_BYTES(3), .READ_LATENCY(2)) dut2 (.clk(clk), .reset_n(reset_n),
        .start(start_v[2]), .key(kv[2][23:0]), .busy(busy_v[2]), .done(done_v[2]), .mem(if2.master));
    rc4_ksa_engine #(.ADDR_W(8), .KEY_BYTES(16), .READ_LATENCY(3)) dut3 (.clk(clk), .reset_n(reset_n),
        .start(start_v[3]), .key(kv[3][127:0]), .busy(busy_v[3]), .done(done_v[3]), .mem(if3.master));

    assign maddr[0] = 8'(if0.mem_addr);  assign wdat[0] = 8'(if0.mem_wdata);  assign wren_v[0] = if0.mem_wren;
    assign maddr[1] = if1.mem_addr;      assign wdat[1] = if1.mem_wdata;      assign wren_v[1] = if1.mem_wren;
    assign maddr[2] = if2.mem_addr;      assign wdat[2] = if2.mem_wdata;      assign wren_v[2] = if2.mem_wren;
    assign maddr[3] = if3.mem_addr;      assign wdat[3] = if3.mem_wdata;      assign wren_v[3] = if3.mem_wren;
    assign if0.mem_rdata = rp[0][0][1:0];
    assign if1.mem_rdata = rp[1][0];
    assign if2.mem_rdata = rp[2][1];
    assign if3.mem_rdata = rp[3][2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAMs: read data appears READ_LATENCY edges after the address.
    always @(posedge clk) begin
        for (int s = 0; s < 4; s++) begin
            if (wren_v[s]) begin
                ram[s][maddr[s]] <= wdat[s];
                wlog.push_back(int'(maddr[s]));
            end
            rp[s][0] <= ram[s][maddr[s]];
            rp[s][1] <= rp[s][0];
            rp[s][2] <= rp[s][1];
        end
        if (fill_go)
            for (int n = 0; n < 256; n++) ram[fill_sel][n] <= fill_id ? 8'(n) : 8'($urandom);
    end

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic ksa_model(input int sel, input logic [255:0] keyv);
        int depth, nb, w, j, t, kb;
        logic [255:0] sh;
        depth = 1 << P_W[sel];  nb = P_NB[sel];  w = P_W[sel];
        exp_wa.delete();
        for (int n = 0; n < depth; n++) begin
            exp_s[n] = n;
            if (INIT_EN) exp_wa.push_back(n);
        end
        j = 0;
        for (int i = 0; i < depth; i++) begin
            sh = keyv >> ((nb - 1 - (i % nb)) * w);
            kb = int'(sh[7:0]) & (depth - 1);
            j = (j + exp_s[i] + kb) % depth;
            exp_wa.push_back(i);
            exp_wa.push_back(j);
            t = exp_s[i];  exp_s[i] = exp_s[j];  exp_s[j] = t;
        end
    endtask

    task automatic run_ksa(input int sel, input logic [255:0] keyv, input bit disturb,
                           input bit do_reset, input string nm);
        int depth, off, lat, cnt, bad_idx;
        depth = 1 << P_W[sel];
        off   = INIT_EN ? depth : 0;
        lat   = off + depth * (2 * P_L[sel] + 5);
        ksa_model(sel, keyv);
        @(negedge clk); fill_sel = sel; fill_id = !INIT_EN; fill_go = 1'b1;
        @(negedge clk); fill_go = 1'b0; wlog.delete();
        kv[sel] = keyv; start_v[sel] = 1'b1;
        @(posedge clk); @(negedge clk); start_v[sel] = 1'b0;
        n_cmp++;
        if (busy_v[sel] !== 1'b1) begin
            n_bad++; $display("FAIL %s busy_after_start: got %b want 1", nm, busy_v[sel]);
        end
        cnt = 0;
        while (done_v[sel] !== 1'b1 && cnt < lat + 100) begin
            @(posedge clk); cnt++; @(negedge clk);
            if (disturb) begin
                if (cnt == 300) start_v[sel] = 1'b1;
                if (cnt == 305) start_v[sel] = 1'b0;
                if (cnt == 400) kv[sel] = rand_key();
            end
            if (do_reset && wlog.size() >= off + 200) begin
                #2 reset_n = 1'b0;
                #1 n_cmp++;
                if ({busy_v[sel], done_v[sel], wren_v[sel], maddr[sel], wdat[sel]} !== 19'd0) begin
                    n_bad++;
                    $display("FAIL %s async_reset_outputs: got busy=%b done=%b wren=%b addr=%0h wdata=%0h want all 0",
                             nm, busy_v[sel], done_v[sel], wren_v[sel], maddr[sel], wdat[sel]);
                end
                @(negedge clk); reset_n = 1'b1;
                return;
            end
        end
        n_cmp++;
        if (done_v[sel] !== 1'b1 || cnt != lat) begin
            n_bad++; $display("FAIL %s done_latency: got %0d cycles (done=%b) want %0d", nm, cnt, done_v[sel], lat);
        end
        n_cmp++;
        if (busy_v[sel] !== 1'b0) begin
            n_bad++; $display("FAIL %s busy_at_done: got %b want 0", nm, busy_v[sel]);
        end
        @(negedge clk);
        n_cmp++;
        if (done_v[sel] !== 1'b0 || busy_v[sel] !== 1'b0) begin
            n_bad++; $display("FAIL %s done_pulse: got done=%b busy=%b want 0 0", nm, done_v[sel], busy_v[sel]);
        end
        bad_idx = -1;
        for (int n = depth - 1; n >= 0; n--) if (ram[sel][n] !== 8'(exp_s[n])) bad_idx = n;
        n_cmp++;
        if (bad_idx >= 0) begin
            n_bad++; $display("FAIL %s ram[%0d]: got %0h want %0h", nm, bad_idx, ram[sel][bad_idx], exp_s[bad_idx]);
        end
        bad_idx = -1;
        if (wlog.size() == exp_wa.size())
            for (int n = exp_wa.size() - 1; n >= 0; n--) if (wlog[n] != exp_wa[n]) bad_idx = n;
        n_cmp++;
        if (wlog.size() != exp_wa.size() || bad_idx >= 0) begin
            n_bad++;
            $display("FAIL %s write_trace: got %0d writes (first diff %0d) want %0d writes",
                     nm, wlog.size(), bad_idx, exp_wa.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1; start_v = '0; fill_go = 1'b0; fill_id = 1'b0; fill_sel = 0;
        for (int s = 0; s < 4; s++) kv[s] = '0;
        #1 reset_n = 1'b0;
        #2;
        for (int s = 0; s < 4; s++) begin
            n_cmp++;
            if ({busy_v[s], done_v[s], wren_v[s], maddr[s], wdat[s]} !== 19'd0) begin
                n_bad++; $display("FAIL reset_state dut%0d: got busy=%b done=%b wren=%b addr=%0h wdata=%0h want all 0",
                                  s, busy_v[s], done_v[s], wren_v[s], maddr[s], wdat[s]);
            end
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_small_ram();
        int tail[8] = '{0, 1, 1, 2, 2, 3, 3, 0};
        int b;
        run_ksa(0, 256'h0, 1'b0, 1'b0, "small_key0");
        n_cmp++;
        if ({ram[0][0], ram[0][1], ram[0][2], ram[0][3]} !== 32'h00020301) begin
            n_bad++; $display("FAIL small_key0_const: got %h want 00020301", {ram[0][0], ram[0][1], ram[0][2], ram[0][3]});
        end
        run_ksa(0, 256'h1, 1'b0, 1'b0, "small_key1");
        n_cmp++;
        if ({ram[0][0], ram[0][1], ram[0][2], ram[0][3]} !== 32'h00020301) begin
            n_bad++; $display("FAIL small_key1_const: got %h want 00020301", {ram[0][0], ram[0][1], ram[0][2], ram[0][3]});
        end
        b = -1;
        if (wlog.size() >= 8) for (int n = 7; n >= 0; n--) if (wlog[wlog.size() - 8 + n] != tail[n]) b = n;
        n_cmp++;
        if (wlog.size() < 8 || b >= 0) begin
            n_bad++; $display("FAIL small_key1_swaps: got %0d writes, first diff at %0d want swaps 01 12 23 30", wlog.size(), b);
        end
        run_ksa(0, rand_key(), 1'b0, 1'b0, "small_rand");
    endtask

    task automatic test_key_vector();
        run_ksa(1, 256'h4B6579, 1'b0, 1'b0, "key_lat1");
        run_ksa(2, 256'h4B6579, 1'b0, 1'b0, "key_lat2");
        run_ksa(3, rand_key(), 1'b0, 1'b0, "long_key_lat3");
    endtask

    task automatic test_random_keys();
        for (int r = 0; r < 2; r++) run_ksa(1, rand_key(), 1'b0, 1'b0, "rand_lat1");
        run_ksa(2, rand_key(), 1'b0, 1'b0, "rand_lat2");
    endtask

    task automatic test_reset_midrun();
        run_ksa(1, rand_key(), 1'b0, 1'b1, "midrun_reset");
        run_ksa(1, rand_key(), 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [255:0] k;
        logic [7:0] saved[256];
        int b;
        k = rand_key();
        run_ksa(1, k, 1'b1, 1'b0, "disturbed");
        for (int n = 0; n < 256; n++) saved[n] = ram[1][n];
        run_ksa(1, k, 1'b0, 1'b0, "restart");
        b = -1;
        for (int n = 255; n >= 0; n--) if (ram[1][n] !== saved[n]) b = n;
        n_cmp++;
        if (b >= 0) begin
            n_bad++; $display("FAIL restart_identical ram[%0d]: got %0h want %0h", b, ram[1][b], saved[b]);
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        test_reset();
        test_small_ram();
        test_key_vector();
        test_random_keys();
        test_reset_midrun();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rc4_ksa_engine.md
# rc4_ksa_engine

Parametrised RC4 key-scheduling engine for the decryption datapath. It optionally initialises an external single-port S-box RAM to the identity permutation, then runs the KSA swap loop over the whole RAM using a key of configurable byte count. It sits between the key-search controller and the S-box RAM. It generalises the fixed 3-byte, 8-bit swap block with three additions: a configurable memory read latency, a one-cycle done pulse with restart capability, and a key index counter that replaces the modulo operator.

## Interface
- ADDR_W, 8: S-box address width. The data width equals ADDR_W and DEPTH = 2**ADDR_W.
- KEY_BYTES, 3: number of key bytes, range 1..32.
- READ_LATENCY, 1: number of cycles from address presented to valid mem_rdata, range 1..3.

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  level start request, sampled only in IDLE
- key  in  KEY_BYTES*ADDR_W  key byte 0 = MSBs, key[KEY_BYTES*ADDR_W-1 -: ADDR_W]
- mem_addr  out  ADDR_W  S-box address
- mem_wdata  out  ADDR_W  S-box write data
- mem_rdata  in  ADDR_W  S-box read data
- mem_wren  out  1  S-box write enable
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, INIT_WR, RD_I, CAP_I, ADD_J, RD_J, CAP_J, WR_I, WR_J, DONE.
- IDLE:
  - When start=1, clear i, j and key index k to 0 and latch key internally. Key changes during busy are ignored.
  - Go to INIT_WR if RC4_INIT_EN is defined, otherwise go to RD_I.
- INIT_WR: write mem[i]=i with wren=1 for one cycle per address. At i=DEPTH-1, clear i and go to RD_I.
- RD_I: mem_addr=i. Hold for READ_LATENCY cycles using a wait counter, then go to CAP_I.
- CAP_I: si <= mem_rdata.
- ADD_J: j <= j + si + key_byte[k], all modulo 2**ADDR_W. Carries are discarded.
- RD_J / CAP_J: same as RD_I / CAP_I with address j; sj <= mem_rdata.
- WR_I: mem_addr=i, mem_wdata=sj, wren=1.
- WR_J: mem_addr=j, mem_wdata=si, wren=1.
  - k <= (k==KEY_BYTES-1) ? 0 : k+1.
  - If i==DEPTH-1, go to DONE. Otherwise i <= i+1 and go to RD_I.
- i==j: both writes go to the same address and the second write restores si, which is the correct self-swap. No special case is needed.
- DONE: done=1, busy=0 for one cycle, then go to IDLE. The engine is restartable with no reset required.
- start while busy is ignored.
- An unknown state encoding returns to IDLE.

## Timing
- Reset (asynchronous, any state): state=IDLE, i=j=k=0, mem_addr=0, mem_wdata=0, mem_wren=0, busy=0, done=0.
- Reset mid-run abandons the loop. RAM contents are undefined afterwards, so a new start (with init) is required.
- All outputs are registered. mem_wren is high only in INIT_WR, WR_I and WR_J.
- Per KSA iteration: 2*READ_LATENCY + 5 cycles. With READ_LATENCY=1 this is 7 cycles, and the full loop for ADDR_W=8 is 1792 cycles.
- Init phase: DEPTH cycles.
- Start accepted at edge N → done high at cycle N + 1 + (init DEPTH) + DEPTH*(2*READ_LATENCY+5).

## Configuration
- RC4_INIT_EN defined: the engine performs the INIT_WR identity fill before the KSA loop, so the RAM needs no separate initialiser.
- RC4_INIT_EN undefined: the INIT_WR state and its logic are removed. The engine assumes the RAM already holds the identity permutation and goes straight from IDLE to RD_I. Latency drops by DEPTH cycles.

## Structure
- Package rc4_pkg: the state enum typedef, default ADDR_W/KEY_BYTES constants, and a key-byte select function.
- One sub-module, rc4_key_index: the k counter with wrap at KEY_BYTES-1 plus the key byte mux. It takes clear and advance inputs and outputs key_byte.
- The top level contains the FSM, the wait counter, and the i/j/si/sj registers.

## Test plan
- ADDR_W=2, KEY_BYTES=1, key=0x0, RC4_INIT_EN on, behavioural RAM with latency 1 → final RAM [0,2,3,1]; done pulses once; busy falls with done.
- Same run with key=0x1 → final RAM [0,2,3,1]. The trace must show the swaps (0,1), (1,2), (2,3), (3,0) in that order.
- ADDR_W=8, KEY_BYTES=3, key=0x4B6579 ("Key"), READ_LATENCY=1 and 2 → RAM equals the software KSA model. Done arrives exactly 256+256*7 and 256+256*9 cycles after start respectively.
- RC4_INIT_EN off, RAM preloaded with identity, ADDR_W=8 → RAM matches the model; done arrives exactly 1792 cycles after start.
- Assert reset_n low at iteration 100, then release it → all outputs read 0 immediately with no clock edge. A new start gives a correct full result.
- Pulse start during busy, and change key mid-run → no effect on sequence or result. A second start after done gives an identical result.
